// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path and a future receiver.
// Holds the parity selectors, the transmitter state encoding and the baud divisor helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: reloadable down-counter whose terminal count marks the end of a bit.
// A restart reloads the full period so the next tick lands exactly DIV cycles later.
module baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (restart || cnt == '0)
      cnt <= CW'(DIV - 1);
    else
      cnt <= cnt - 1'b1;
  end

  // Depends only on the counter, so the FSM may derive restart from it without a loop.
  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: small write FIFO feeding a start/data/parity/stop framer.
//   state     | meaning
//   ST_IDLE   | line high, waiting for a FIFO entry
//   ST_START  | driving the start bit (low)
//   ST_DATA   | shifting payload out LSB first
//   ST_PARITY | driving the parity bit (skipped when PAR_NONE)
//   ST_STOP   | driving STOP_BITS high periods, then pop next or go idle
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_ODD,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 tx_enable,
  output logic                 tx_out,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(DATA_BITS);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, empty, push, pop;
  logic [DATA_BITS-1:0] head;

  tx_state_t            state;
  logic [DATA_BITS-1:0] shifter;
  logic [BCW-1:0]       bit_cnt;
  logic                 stop_cnt;
  logic                 par_bit;
  logic                 tick;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_ODD) ? ~^d : ^d;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
  // Full is judged before any same-edge pop, so a write at full is always dropped.
  assign push  = tx_enable && !full;
  assign pop   = !empty && ((state == ST_IDLE) ||
                            (state == ST_STOP && tick && stop_cnt == 1'b0));

  assign tx_ready = !full;
  assign tx_busy  = (state != ST_IDLE) || !empty;

  baud_tick #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (pop),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      overflow <= tx_enable && full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_out   <= 1'b1;
      shifter  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
    end else if (pop) begin
      state   <= ST_START;
      tx_out  <= 1'b0;
      shifter <= head;
      par_bit <= parity_of(head);
    end else if (tick) begin
      case (state)
        ST_START: begin
          state   <= ST_DATA;
          tx_out  <= shifter[0];
          shifter <= shifter >> 1;
          bit_cnt <= BCW'(DATA_BITS - 1);
        end
        ST_DATA: begin
          if (bit_cnt == '0) begin
            if (PARITY != PAR_NONE) begin
              state  <= ST_PARITY;
              tx_out <= par_bit;
            end else begin
              state    <= ST_STOP;
              tx_out   <= 1'b1;
              stop_cnt <= (STOP_BITS == 2);
            end
          end else begin
            tx_out  <= shifter[0];
            shifter <= shifter >> 1;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_PARITY: begin
          state    <= ST_STOP;
          tx_out   <= 1'b1;
          stop_cnt <= (STOP_BITS == 2);
        end
        ST_STOP: begin
          // A non-empty FIFO at the last stop tick is handled by the pop branch above.
          if (stop_cnt == 1'b0) begin
            state  <= ST_IDLE;
            tx_out <= 1'b1;
          end else begin
            stop_cnt <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8O1 (with FIFO/overflow/reset cases), 7E2 and 5N1 frames.
// Frames are checked every clock against hand-computed bit sequences (bit 0 = start bit).
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [4:0] data_c;
  logic       en_a, en_b, en_c;
  logic       tx_a, ready_a, busy_a, ovf_a;
  logic       tx_b, ready_b, busy_b, ovf_b;
  logic       tx_c, ready_c, busy_c, ovf_c;
  logic       cur_tx, cur_busy;
  int         sel;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] fifo_bytes [5];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ), .BAUD (BAUD), .DATA_BITS (8),
    .PARITY (PAR_ODD), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) dut_a (
    .clk (clk), .rst (rst), .data (data_a), .tx_enable (en_a),
    .tx_out (tx_a), .tx_ready (ready_a), .tx_busy (busy_a), .overflow (ovf_a)
  );

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ), .BAUD (BAUD), .DATA_BITS (7),
    .PARITY (PAR_EVEN), .STOP_BITS (2), .FIFO_DEPTH (4)
  ) dut_b (
    .clk (clk), .rst (rst), .data (data_b), .tx_enable (en_b),
    .tx_out (tx_b), .tx_ready (ready_b), .tx_busy (busy_b), .overflow (ovf_b)
  );

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ), .BAUD (BAUD), .DATA_BITS (5),
    .PARITY (PAR_NONE), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) dut_c (
    .clk (clk), .rst (rst), .data (data_c), .tx_enable (en_c),
    .tx_out (tx_c), .tx_ready (ready_c), .tx_busy (busy_c), .overflow (ovf_c)
  );

  always_comb begin
    cur_tx   = tx_a;
    cur_busy = busy_a;
    case (sel)
      1: begin cur_tx = tx_b; cur_busy = busy_b; end
      2: begin cur_tx = tx_c; cur_busy = busy_c; end
      default: ;
    endcase
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 8O1 frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [15:0] f8o1(input logic [7:0] d);
    return {5'b0, 1'b1, ~^d, d, 1'b0};
  endfunction

  // Called one cycle after the edge that put bit k0 of the frame on the line.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int len, input int k0);
    for (int k = k0; k < len * DIV; k++) begin
      check(tag, 32'(cur_tx), 32'(bits[k / DIV]));
      if (k == len * DIV - 1)
        check({tag, "_busy_last"}, 32'(cur_busy), 1);
      step(1);
    end
  endtask

  initial begin
    sel    = 0;
    rst    = 1'b1;
    en_a   = 1'b0; en_b = 1'b0; en_c = 1'b0;
    data_a = '0;   data_b = '0; data_c = '0;
    fifo_bytes[0] = 8'hA3; fifo_bytes[1] = 8'h0F; fifo_bytes[2] = 8'hFF;
    fifo_bytes[3] = 8'h00; fifo_bytes[4] = 8'h81;
    step(2);

    check("rst_tx_a",    32'(tx_a),    1);
    check("rst_ready_a", 32'(ready_a), 1);
    check("rst_busy_a",  32'(busy_a),  0);
    check("rst_ovf_a",   32'(ovf_a),   0);
    check("rst_tx_b",    32'(tx_b),    1);
    check("rst_ready_b", 32'(ready_b), 1);
    check("rst_busy_b",  32'(busy_b),  0);
    check("rst_ovf_b",   32'(ovf_b),   0);
    check("rst_tx_c",    32'(tx_c),    1);
    check("rst_ready_c", 32'(ready_c), 1);
    check("rst_busy_c",  32'(busy_c),  0);
    check("rst_ovf_c",   32'(ovf_c),   0);

    // Single 8O1 frame of 0x55
    rst    = 1'b0;
    data_a = 8'h55;
    en_a   = 1'b1;
    step(1);
    en_a = 1'b0;
    check("accept_tx_idle", 32'(tx_a),   1);
    check("accept_busy",    32'(busy_a), 1);
    step(1);
    run_frame("f55", 16'h06AA, 11, 0);
    check("f55_end_tx",   32'(tx_a),   1);
    check("f55_end_busy", 32'(busy_a), 0);

    // Five writes while idle, then one write into a full FIFO
    for (int i = 0; i < 5; i++) begin
      data_a = fifo_bytes[i];
      en_a   = 1'b1;
      check("fill_ready", 32'(ready_a), 1);
      step(1);
    end
    data_a = 8'hEE;
    check("full_ready", 32'(ready_a), 0);
    check("pre_ovf",    32'(ovf_a),   0);
    step(1);
    en_a = 1'b0;
    check("ovf_pulse", 32'(ovf_a), 1);
    step(1);
    check("ovf_clear", 32'(ovf_a), 0);
    run_frame("fifo0", f8o1(fifo_bytes[0]), 11, 5);
    for (int i = 1; i < 5; i++)
      run_frame("fifo_n", f8o1(fifo_bytes[i]), 11, 0);
    check("fifo_end_tx",   32'(tx_a),    1);
    check("fifo_end_busy", 32'(busy_a),  0);
    check("fifo_end_rdy",  32'(ready_a), 1);

    // Reset in cycle 35 of a frame, with a write attempted during reset
    data_a = 8'h00;
    en_a   = 1'b1;
    step(1);
    en_a = 1'b0;
    step(1);
    check("abort_start", 32'(tx_a), 0);
    step(35);
    check("abort_pre_rst", 32'(tx_a), 0);
    rst    = 1'b1;
    en_a   = 1'b1;
    data_a = 8'hC3;
    step(1);
    check("abort_tx",    32'(tx_a),    1);
    check("abort_busy",  32'(busy_a),  0);
    check("abort_ready", 32'(ready_a), 1);
    check("abort_ovf",   32'(ovf_a),   0);
    rst  = 1'b0;
    en_a = 1'b0;
    step(1);
    check("rst_write_ignored", 32'(busy_a), 0);
    for (int i = 0; i < 30; i++) begin
      check("abort_line_idle", 32'(tx_a), 1);
      step(1);
    end
    data_a = 8'h55;
    en_a   = 1'b1;
    step(1);
    en_a = 1'b0;
    step(1);
    run_frame("post_rst", 16'h06AA, 11, 0);
    check("post_rst_busy", 32'(busy_a), 0);

    // 7E2 frame of 0x7F: 0,1111111,1,1,1
    sel    = 1;
    data_b = 7'h7F;
    en_b   = 1'b1;
    step(1);
    en_b = 1'b0;
    check("b_accept_tx", 32'(tx_b), 1);
    step(1);
    run_frame("f7e2", 16'h07FE, 11, 0);
    check("f7e2_end_tx",   32'(tx_b),   1);
    check("f7e2_end_busy", 32'(busy_b), 0);

    // 5N1 frame of 0x13: 0,1,1,0,0,1,1
    sel    = 2;
    data_c = 5'h13;
    en_c   = 1'b1;
    step(1);
    en_c = 1'b0;
    check("c_accept_tx", 32'(tx_c), 1);
    step(1);
    run_frame("f5n1", 16'h0066, 7, 0);
    check("f5n1_end_tx",   32'(tx_c),   1);
    check("f5n1_end_busy", 32'(busy_c), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
